str_to_ram_trig: RTL and testbench

- Parametrised stream-capture buffer, successor to the 16-bit fixed stream-to-RAM block.
- Packs DW-bit stream samples into 32-bit words of an on-chip buffer.
- Two modes: single-shot fill, and circular pre/post-trigger capture.
- Exposes control, status and buffer contents on the system bus. Sits between an acquisition stream (ADC/decimator) and the CPU bus.

---
 rtl/str_ram_pkg.sv | 54 +++++
 rtl/ram_sdp.sv | 23 ++
 rtl/str_to_ram_trig.sv | 247 ++++++++++++++++++++++++
 tb/tb_str_to_ram_trig.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/str_ram_pkg.sv
// Shared types and constants for the stream-capture buffer.
package str_ram_pkg;

  // Capture FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Register word offsets (bus_addr[4:2]).
  localparam logic [2:0] REG_CTL  = 3'd0;
  localparam logic [2:0] REG_CFG  = 3'd1;
  localparam logic [2:0] REG_POST = 3'd2;
  localparam logic [2:0] REG_WPTR = 3'd3;
  localparam logic [2:0] REG_TPTR = 3'd4;

  // CTL write bits.
  localparam int CTL_START = 0;
  localparam int CTL_STOP  = 1;
  localparam int CTL_TRIG  = 2;

  // CTL read (status) bits.
  localparam int STS_ACTIVE = 0;
  localparam int STS_TRIG   = 1;
  localparam int STS_DONE   = 2;

  // CFG bits.
  localparam int CFG_MODE = 0;

  // Samples packed into one 32-bit word.
  function automatic int pk_of(input int dw);
    return 32 / dw;
  endfunction

  // log2 of the samples-per-word count.
  function automatic int lpk_of(input int dw);
    int r;
    case (dw)
      8:       r = 2;
      16:      r = 1;
      default: r = 0;
    endcase
    return r;
  endfunction

  // Width of the sample pointer.
  function automatic int ptr_width(input int dw, input int aw);
    return aw + lpk_of(dw);
  endfunction

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-during-write to the same address returns the old contents.
module ram_sdp #(
  parameter int WIDTH = 32,
  parameter int ABITS = 13
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**ABITS];

  // Write port and registered read port share one clocked process.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/str_to_ram_trig.sv
// Stream-capture buffer: packs DW-bit samples into 32-bit words of an
// on-chip RAM, in single-shot fill or circular pre/post-trigger mode.
//
// Stream handshake: a sample transfers on every cycle where str_tvalid and
// str_tready are both high. str_tready is high in every cycle after reset,
// so upstream never stalls; samples arriving outside a capture are dropped.
// Bus handshake: bus_wen/bus_ren are single-cycle strobes; bus_ack (with
// bus_rdata and bus_err) follows exactly one cycle later.
module str_to_ram_trig
  import str_ram_pkg::*;
#(
  parameter int DW = 16,   // 8, 16 or 32
  parameter int AW = 13,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trg_ext,
  input  logic [DW-1:0] str_tdata,
  input  logic          str_tvalid,
  input  logic          str_tlast,
  output logic          str_tready,
  input  logic [31:0]   bus_addr,
  input  logic [31:0]   bus_wdata,
  input  logic          bus_wen,
  input  logic          bus_ren,
  output logic [31:0]   bus_rdata,
  output logic          bus_ack,
  output logic          bus_err,
  output logic          done
);

  localparam int PK  = pk_of(DW);
  localparam int LPK = lpk_of(DW);
  localparam int PW  = ptr_width(DW, AW);

  state_t        state_q, state_d;
  logic          rdy_q;
  logic          trg_q;
  logic [PW-1:0] wptr_q, tptr_q;
  logic [31:0]   pack_q;
  logic          pend_q;
  logic [CW-1:0] cnt_q, post_q, post_act_q;
  logic          mode_q;
  logic          trig_flag_q;

  logic          ack_q, err_q, rd_buf_q;
  logic [31:0]   reg_rd_q;
  logic [31:0]   ram_rdata;

  // Bus decode
  logic       buf_sel;
  logic [2:0] reg_idx;
  logic       ctl_wr, stop_req, start_req, sw_trg, do_start;
  logic       trg_rise, trig_take;
  logic       reg_writable;

  // Capture datapath
  logic          xfer, capturing, samp_in;
  logic [PW-1:0] lane;
  logic          lane_last;
  logic [31:0]   merged;
  logic          fill_end, post_end, post_zero, flush;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   reg_val;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus_addr[31:AW+3], bus_addr[1:0]};

  assign str_tready = rdy_q;
  assign done       = (state_q == ST_DONE);
  assign bus_ack    = ack_q;
  assign bus_err    = err_q;
  assign bus_rdata  = rd_buf_q ? ram_rdata : reg_rd_q;

  // Bus decode, control strobes and trigger qualification.
  always_comb begin
    buf_sel      = bus_addr[AW+2];
    reg_idx      = bus_addr[4:2];
    ctl_wr       = bus_wen & ~buf_sel & (reg_idx == REG_CTL);
    stop_req     = ctl_wr & bus_wdata[CTL_STOP];
    start_req    = ctl_wr & bus_wdata[CTL_START] & ~stop_req;
    sw_trg       = ctl_wr & bus_wdata[CTL_TRIG];
    do_start     = start_req & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    trg_rise     = trg_ext & ~trg_q;
    // A start in the same write masks any trigger.
    trig_take    = (state_q == ST_ARMED) & (trg_rise | sw_trg) & ~start_req & ~stop_req;
    reg_writable = (reg_idx == REG_CTL) | (reg_idx == REG_CFG) | (reg_idx == REG_POST);
  end

  // Sample packing and RAM write generation.
  always_comb begin
    xfer      = str_tvalid & rdy_q;
    capturing = (state_q == ST_FILL) | (state_q == ST_ARMED) |
                ((state_q == ST_POST) & (cnt_q != '0));
    samp_in   = xfer & capturing & ~stop_req;
    lane      = wptr_q & PW'(PK - 1);
    lane_last = (lane == PW'(PK - 1));
    merged    = pack_q;
    for (int i = 0; i < PK; i++) begin
      if (lane == PW'(i)) merged[i*DW +: DW] = str_tdata;
    end
    fill_end  = (state_q == ST_FILL) & samp_in & (str_tlast | (wptr_q == '1));
    post_end  = (state_q == ST_POST) & samp_in & (cnt_q == CW'(1));
    post_zero = (state_q == ST_POST) & (cnt_q == '0) & ~stop_req;
    // Partially filled word still held in the packer gets written on exit.
    flush     = pend_q & (stop_req | post_zero);
    ram_we    = (samp_in & (lane_last | str_tlast | fill_end | post_end)) | flush;
    ram_wdata = samp_in ? merged : pack_q;
    ram_waddr = AW'(wptr_q >> LPK);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (stop_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (do_start) state_d = mode_q ? ST_ARMED : ST_FILL;
        end
        ST_FILL: begin
          if (fill_end) state_d = ST_DONE;
        end
        ST_ARMED: begin
          if (trig_take) state_d = ST_POST;
        end
        ST_POST: begin
          if (post_zero | post_end) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Pointers, packer, post-trigger counter and configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q       <= 1'b0;
      trg_q       <= 1'b0;
      wptr_q      <= '0;
      tptr_q      <= '0;
      pack_q      <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      post_q      <= '0;
      post_act_q  <= '0;
      mode_q      <= 1'b0;
      trig_flag_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      trg_q <= trg_ext;
      if (bus_wen & ~buf_sel & (reg_idx == REG_CFG))  mode_q <= bus_wdata[CFG_MODE];
      if (bus_wen & ~buf_sel & (reg_idx == REG_POST)) post_q <= bus_wdata[CW-1:0];

      if (stop_req) begin
        pack_q      <= '0;
        pend_q      <= 1'b0;
        trig_flag_q <= 1'b0;
      end else if (do_start) begin
        wptr_q      <= '0;
        tptr_q      <= '0;
        pack_q      <= '0;
        pend_q      <= 1'b0;
        cnt_q       <= '0;
        trig_flag_q <= 1'b0;
        post_act_q  <= post_q;
      end else begin
        if (samp_in) begin
          wptr_q <= wptr_q + PW'(1);
          if (lane_last) begin
            pack_q <= '0;
            pend_q <= 1'b0;
          end else begin
            // Keep earlier lanes so a later write of this word retains them.
            pack_q <= merged;
            pend_q <= ~ram_we;
          end
        end else if (post_zero) begin
          pend_q <= 1'b0;
        end

        if (trig_take) begin
          tptr_q      <= samp_in ? wptr_q : (wptr_q - PW'(1));
          cnt_q       <= post_act_q;
          trig_flag_q <= 1'b1;
        end else if ((state_q == ST_POST) & samp_in) begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end
  end

  // Register read mux.
  always_comb begin
    reg_val = '0;
    case (reg_idx)
      REG_CTL: begin
        reg_val[STS_ACTIVE] = (state_q == ST_FILL) | (state_q == ST_ARMED) | (state_q == ST_POST);
        reg_val[STS_TRIG]   = trig_flag_q;
        reg_val[STS_DONE]   = (state_q == ST_DONE);
      end
      REG_CFG:  reg_val[CFG_MODE] = mode_q;
      REG_POST: reg_val = 32'(post_q);
      REG_WPTR: reg_val = 32'(wptr_q);
      REG_TPTR: reg_val = 32'(tptr_q);
      default:  reg_val = '0;
    endcase
  end

  // Bus response: ack, error and register read data one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_buf_q <= 1'b0;
      reg_rd_q <= '0;
    end else begin
      ack_q    <= bus_wen | bus_ren;
      err_q    <= bus_wen & (buf_sel | ~reg_writable);
      rd_buf_q <= bus_ren & buf_sel;
      reg_rd_q <= (bus_ren & ~buf_sel) ? reg_val : '0;
    end
  end

  ram_sdp #(
    .WIDTH (32),
    .ABITS (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (bus_addr[AW+1:2]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_str_to_ram_trig.sv
// Directed bench for str_to_ram_trig: a 16-bit instance (A) and an 8-bit
// instance (B), both with a 16-word buffer.
module tb_str_to_ram_trig;

  logic clk;

  // Instance A: DW=16, AW=4 (NS=32, buffer at 0x40).
  logic        a_rst, a_trg, a_tvalid, a_tlast, a_tready;
  logic [15:0] a_tdata;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_wen, a_ren, a_ack, a_err, a_done;

  // Instance B: DW=8, AW=4 (NS=64, buffer at 0x40).
  logic        b_rst, b_trg, b_tvalid, b_tlast, b_tready;
  logic [7:0]  b_tdata;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_wen, b_ren, b_ack, b_err, b_done;

  int vectors    = 0;
  int miscompares = 0;

  str_to_ram_trig #(.DW(16), .AW(4), .CW(32)) dut_a (
    .clk(clk), .rst(a_rst), .trg_ext(a_trg),
    .str_tdata(a_tdata), .str_tvalid(a_tvalid), .str_tlast(a_tlast), .str_tready(a_tready),
    .bus_addr(a_addr), .bus_wdata(a_wdata), .bus_wen(a_wen), .bus_ren(a_ren),
    .bus_rdata(a_rdata), .bus_ack(a_ack), .bus_err(a_err), .done(a_done)
  );

  str_to_ram_trig #(.DW(8), .AW(4), .CW(32)) dut_b (
    .clk(clk), .rst(b_rst), .trg_ext(b_trg),
    .str_tdata(b_tdata), .str_tvalid(b_tvalid), .str_tlast(b_tlast), .str_tready(b_tready),
    .bus_addr(b_addr), .bus_wdata(b_wdata), .bus_wen(b_wen), .bus_ren(b_ren),
    .bus_rdata(b_rdata), .bus_ack(b_ack), .bus_err(b_err), .done(b_done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input bit on_b, input logic [31:0] addr, input logic [31:0] data,
                        output logic ack, output logic err);
    if (on_b) begin b_addr = addr; b_wdata = data; b_wen = 1'b1; end
    else      begin a_addr = addr; a_wdata = data; a_wen = 1'b1; end
    tick();
    a_wen = 1'b0;
    b_wen = 1'b0;
    ack = on_b ? b_ack : a_ack;
    err = on_b ? b_err : a_err;
  endtask

  task automatic bus_rd(input bit on_b, input logic [31:0] addr,
                        output logic [31:0] data, output logic ack, output logic err);
    if (on_b) begin b_addr = addr; b_ren = 1'b1; end
    else      begin a_addr = addr; a_ren = 1'b1; end
    tick();
    a_ren = 1'b0;
    b_ren = 1'b0;
    data = on_b ? b_rdata : a_rdata;
    ack  = on_b ? b_ack : a_ack;
    err  = on_b ? b_err : a_err;
  endtask

  task automatic a_send(input logic [15:0] d, input logic last);
    a_tdata = d; a_tlast = last; a_tvalid = 1'b1;
    tick();
    a_tvalid = 1'b0; a_tlast = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] d);
    b_tdata = d; b_tvalid = 1'b1;
    tick();
    b_tvalid = 1'b0;
  endtask

  logic        ack, err;
  logic [31:0] rd;

  initial begin
    a_rst = 1'b1; a_trg = 1'b0; a_tvalid = 1'b0; a_tlast = 1'b0; a_tdata = '0;
    a_addr = '0; a_wdata = '0; a_wen = 1'b0; a_ren = 1'b0;
    b_rst = 1'b1; b_trg = 1'b0; b_tvalid = 1'b0; b_tlast = 1'b0; b_tdata = '0;
    b_addr = '0; b_wdata = '0; b_wen = 1'b0; b_ren = 1'b0;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_tready", {31'b0, a_tready}, 32'd0);
    check("rst_rdata",  a_rdata,           32'd0);
    check("rst_ack",    {31'b0, a_ack},    32'd0);
    check("rst_err",    {31'b0, a_err},    32'd0);
    check("rst_done",   {31'b0, a_done},   32'd0);
    check("rst_b_tready", {31'b0, b_tready}, 32'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
    check("tready_up", {31'b0, a_tready}, 32'd1);

    // ---- single fill of 32 samples ----
    bus_wr(0, 32'h04, 32'h0, ack, err);
    check("cfg_wr_err", {30'b0, ack, err}, 32'b10);
    bus_wr(0, 32'h00, 32'h1, ack, err);
    for (int n = 1; n <= 32; n++) begin
      a_send(16'(n), 1'b0);
      if (n == 31) check("fill_done_early", {31'b0, a_done}, 32'd0);
      if (n == 32) check("fill_done",       {31'b0, a_done}, 32'd1);
    end
    bus_rd(0, 32'h40, rd, ack, err);
    check("fill_word0",  rd, 32'h0002_0001);
    bus_rd(0, 32'h7C, rd, ack, err);
    check("fill_word15", rd, 32'h0020_001F);
    bus_rd(0, 32'h0C, rd, ack, err);
    check("fill_wptr",   rd, 32'd0);
    bus_rd(0, 32'h00, rd, ack, err);
    check("fill_sts",    rd, 32'h4);

    // ---- single fill terminated by tlast ----
    bus_wr(0, 32'h00, 32'h1, ack, err);
    a_send(16'h000A, 1'b0);
    a_send(16'h000B, 1'b0);
    check("tlast_done_early", {31'b0, a_done}, 32'd0);
    a_send(16'h000C, 1'b1);
    check("tlast_done", {31'b0, a_done}, 32'd1);
    bus_rd(0, 32'h40, rd, ack, err);
    check("tlast_word0", rd, 32'h000B_000A);
    bus_rd(0, 32'h44, rd, ack, err);
    check("tlast_word1", rd, 32'h0000_000C);
    bus_rd(0, 32'h0C, rd, ack, err);
    check("tlast_wptr",  rd, 32'd3);

    // ---- circular capture, POST=5, sw trigger with sample 40 ----
    bus_wr(0, 32'h04, 32'h1, ack, err);
    bus_wr(0, 32'h08, 32'd5, ack, err);
    bus_wr(0, 32'h00, 32'h1, ack, err);
    for (int n = 0; n <= 45; n++) begin
      a_tdata = 16'(n); a_tvalid = 1'b1;
      if (n == 40) begin a_addr = 32'h00; a_wdata = 32'h4; a_wen = 1'b1; end
      tick();
      a_wen = 1'b0;
      if (n == 40) check("swtrg_ack", {30'b0, a_ack, a_err}, 32'b10);
      if (n == 44) check("circ_done_early", {31'b0, a_done}, 32'd0);
      if (n == 45) check("circ_done",       {31'b0, a_done}, 32'd1);
    end
    a_tvalid = 1'b0;
    bus_rd(0, 32'h10, rd, ack, err);
    check("circ_tptr",  rd, 32'd8);
    bus_rd(0, 32'h58, rd, ack, err);
    check("circ_word6", rd, 32'h002D_002C);
    bus_rd(0, 32'h50, rd, ack, err);
    check("circ_word4", rd, 32'h0029_0028);
    bus_rd(0, 32'h40, rd, ack, err);
    check("circ_word0", rd, 32'h0021_0020);
    bus_rd(0, 32'h0C, rd, ack, err);
    check("circ_wptr",  rd, 32'd14);
    bus_rd(0, 32'h00, rd, ack, err);
    check("circ_sts",   rd, 32'h6);

    // ---- POST=0, external trigger edge ----
    bus_wr(0, 32'h08, 32'd0, ack, err);
    bus_wr(0, 32'h00, 32'h1, ack, err);
    a_trg = 1'b1;
    tick();
    check("p0_done_trgcycle", {31'b0, a_done}, 32'd0);
    tick();
    check("p0_done_next",     {31'b0, a_done}, 32'd1);
    bus_rd(0, 32'h10, rd, ack, err);
    check("p0_tptr", rd, 32'd31);
    bus_wr(0, 32'h00, 32'h1, ack, err);
    repeat (3) tick();
    check("held_trg_no_retrig", {31'b0, a_done}, 32'd0);
    bus_rd(0, 32'h00, rd, ack, err);
    check("held_trg_sts", rd, 32'h1);
    a_trg = 1'b0;
    tick();
    a_trg = 1'b1;
    tick();
    tick();
    check("retrig_done", {31'b0, a_done}, 32'd1);

    // ---- bus access checks ----
    bus_wr(0, 32'h40, 32'hDEAD_BEEF, ack, err);
    check("buf_wr_ackerr", {30'b0, ack, err}, 32'b11);
    bus_wr(0, 32'h0C, 32'h5, ack, err);
    check("ro_wr_ackerr",  {30'b0, ack, err}, 32'b11);
    bus_rd(0, 32'h14, rd, ack, err);
    check("undef_rd_data",   rd, 32'd0);
    check("undef_rd_ackerr", {30'b0, ack, err}, 32'b10);
    bus_wr(0, 32'h00, 32'h3, ack, err);
    bus_rd(0, 32'h00, rd, ack, err);
    check("start_stop_sts", rd & 32'h5, 32'h0);

    // ---- stop during POST flushes partial word ----
    bus_wr(0, 32'h08, 32'd10, ack, err);
    bus_wr(0, 32'h00, 32'h1, ack, err);
    a_send(16'h0100, 1'b0);
    a_send(16'h0101, 1'b0);
    a_send(16'h0102, 1'b0);
    bus_wr(0, 32'h00, 32'h4, ack, err);
    bus_rd(0, 32'h00, rd, ack, err);
    check("post_sts", rd, 32'h3);
    bus_wr(0, 32'h00, 32'h2, ack, err);
    check("stop_done", {31'b0, a_done}, 32'd0);
    bus_rd(0, 32'h00, rd, ack, err);
    check("stop_sts", rd & 32'h5, 32'h0);
    bus_rd(0, 32'h40, rd, ack, err);
    check("stop_word0", rd, 32'h0101_0100);
    bus_rd(0, 32'h44, rd, ack, err);
    check("stop_flush_word1", rd, 32'h0000_0102);
    bus_rd(0, 32'h0C, rd, ack, err);
    check("stop_wptr", rd, 32'd3);

    // ---- DW=8 packing and reset mid-ARMED ----
    bus_wr(1, 32'h00, 32'h1, ack, err);
    b_send(8'h11);
    b_send(8'h22);
    b_send(8'h33);
    b_send(8'h44);
    bus_rd(1, 32'h40, rd, ack, err);
    check("b_word0", rd, 32'h4433_2211);
    bus_wr(1, 32'h00, 32'h2, ack, err);
    bus_wr(1, 32'h04, 32'h1, ack, err);
    bus_wr(1, 32'h00, 32'h1, ack, err);
    bus_rd(1, 32'h00, rd, ack, err);
    check("b_armed_sts", rd, 32'h1);
    b_send(8'h55);
    b_send(8'h66);
    b_rst = 1'b1;
    tick();
    check("b_rst_tready", {31'b0, b_tready}, 32'd0);
    check("b_rst_done",   {31'b0, b_done},   32'd0);
    b_rst = 1'b0;
    tick();
    check("b_tready_up",  {31'b0, b_tready}, 32'd1);
    bus_rd(1, 32'h00, rd, ack, err);
    check("b_rst_sts",  rd, 32'h0);
    bus_rd(1, 32'h0C, rd, ack, err);
    check("b_rst_wptr", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
